gesture_vote_filter: RTL

GESTURE_VOTE_FILTER -- requirements
Module: gesture_vote_filter

---
 rtl/gesture_vote_filter_pkg.sv | 22 ++
 rtl/gesture_vote_filter_vote_counter.sv | 26 ++
 rtl/gesture_vote_filter.sv | 127 ++++++++++++
 3 files changed

// File: rtl/gesture_vote_filter_pkg.sv
// Shared definitions for the gesture vote filter and the game controller:
// filter state encoding, class codes and default window sizing.
package gesture_vote_filter_pkg;

    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_TRACK  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam logic [1:0] ROCK     = 2'd0;
    localparam logic [1:0] PAPER    = 2'd1;
    localparam logic [1:0] SCISSORS = 2'd2;

    // Any code >= the class count is unknown; this is the canonical one.
    localparam logic [3:0] LABEL_UNKNOWN = 4'hF;

    localparam int DEFAULT_DEPTH   = 8;
    localparam int DEFAULT_THRESH  = 6;
    localparam int DEFAULT_CLASSES = 3;

endpackage

// File: rtl/gesture_vote_filter_vote_counter.sv
// Per-class vote counter; simultaneous inc and dec cancel so a same-class
// eviction/insert leaves the count untouched.
module vote_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && !dec) begin
            count <= count + W'(1);
        end else if (dec && !inc) begin
            count <= count - W'(1);
        end
    end

endmodule

// File: rtl/gesture_vote_filter.sv
// Sliding-window majority vote over classifier labels: a circular buffer of
// recent labels with per-class counters, and a FILL/TRACK/LOCKED decision stage.
module gesture_vote_filter
    import gesture_vote_filter_pkg::*;
#(
    parameter int DEPTH       = DEFAULT_DEPTH,
    parameter int THRESH      = DEFAULT_THRESH,
    parameter int NUM_CLASSES = DEFAULT_CLASSES,
    parameter int TIMEOUT     = 25_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] label_in,
    input  logic       label_valid,
    input  logic       clear,
    output logic [1:0] gesture,
    output logic       gesture_valid,
    output logic       gesture_update,
    output logic [4:0] fill_count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    logic [3:0]    win_buf [DEPTH];
    logic [PW-1:0] wptr;
    logic [CW-1:0] cnt [NUM_CLASSES];
    logic [IW-1:0] idle_cnt;
    logic [3:0]    evicted;
    logic          full, timeout_hit, flush, accept;

    state_t        state, state_nxt;
    logic [1:0]    gest_nxt, pick;
    logic          found, held;

    assign full        = (fill_count == 5'(DEPTH));
    assign evicted     = win_buf[wptr];
    assign timeout_hit = (TIMEOUT != 0) && !label_valid && (idle_cnt == IW'(TIMEOUT - 1));
    assign flush       = clear || timeout_hit;
    assign accept      = label_valid && !flush;

    for (genvar c = 0; c < NUM_CLASSES; c++) begin : g_cls
        logic inc, dec;
        assign inc = accept && (label_in == 4'(c));
        assign dec = accept && full && (evicted == 4'(c));
        vote_counter #(.W(CW)) u_cnt (
            .clk   (clk),
            .rst_n (rst_n),
            .clr   (flush),
            .inc   (inc),
            .dec   (dec),
            .count (cnt[c])
        );
    end

    // Window storage needs no reset; fill_count says which slots are live.
    always_ff @(posedge clk) begin
        if (accept) win_buf[wptr] <= label_in;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr       <= '0;
            fill_count <= '0;
            idle_cnt   <= '0;
        end else begin
            if (flush) begin
                wptr       <= '0;
                fill_count <= '0;
            end else if (accept) begin
                wptr <= wptr + PW'(1);
                if (!full) fill_count <= fill_count + 5'd1;
            end
            if (flush || label_valid) idle_cnt <= '0;
            else if (TIMEOUT != 0)    idle_cnt <= idle_cnt + IW'(1);
        end
    end

    // The held class survives ties; otherwise the lowest qualifying index wins.
    always_comb begin
        state_nxt = state;
        gest_nxt  = gesture;
        found     = 1'b0;
        held      = 1'b0;
        pick      = ROCK;
        for (int c = 0; c < NUM_CLASSES; c++) begin
            if (cnt[c] >= CW'(THRESH)) begin
                if (!found) begin
                    found = 1'b1;
                    pick  = 2'(c);
                end
                if (state == ST_LOCKED && gesture == 2'(c)) held = 1'b1;
            end
        end
        if (held) begin
            state_nxt = ST_LOCKED;
        end else if (found) begin
            state_nxt = ST_LOCKED;
            gest_nxt  = pick;
        end else if (full) begin
            state_nxt = ST_TRACK;
        end else begin
            state_nxt = ST_FILL;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_FILL;
            gesture        <= ROCK;
            gesture_valid  <= 1'b0;
            gesture_update <= 1'b0;
        end else if (flush) begin
            state          <= ST_FILL;
            gesture_valid  <= 1'b0;
            gesture_update <= gesture_valid;
        end else begin
            state          <= state_nxt;
            gesture        <= gest_nxt;
            gesture_valid  <= (state_nxt == ST_LOCKED);
            gesture_update <= (gest_nxt != gesture) ||
                              ((state_nxt == ST_LOCKED) != gesture_valid);
        end
    end

endmodule
